// File: rtl/cpu_controle_seq.sv
// rtl/cpu_controle_seq.sv - control sequencer issuing register codes and ULA select for the 4-bit datapath
module cpu_controle_seq #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [3:0]    instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          y_lsb,
  output logic [CW-1:0] tx,
  output logic [CW-1:0] ty,
  output logic [CW-1:0] tz,
  output logic [3:0]    ula_op,
  output logic          done,
  output logic          illegal
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_MUL_ADD   = 3'd2;
  localparam logic [2:0] S_MUL_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [CW-1:0] C_CLEAR  = CW'(0);
  localparam logic [CW-1:0] C_LOAD   = CW'(1);
  localparam logic [CW-1:0] C_HOLD   = CW'(2);
  localparam logic [CW-1:0] C_SHIFTR = CW'(3);
  localparam logic [CW-1:0] C_SHIFTL = CW'(4);

  localparam logic [3:0] U_PASSY = 4'd0;
  localparam logic [3:0] U_ADD   = 4'd1;
  localparam logic [3:0] U_SUB   = 4'd2;
  localparam logic [3:0] U_ADDZ  = 4'd3;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_LDX  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MOVZ = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;

  logic [2:0]      state;
  logic [3:0]      opcode;
  logic [CNTW-1:0] cnt;
  logic            accept;

  assign instr_ready = (state == S_IDLE);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      opcode <= OP_NOP;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            opcode <= instr;
            if (instr == OP_MUL) begin
              state <= S_MUL_ADD;
              cnt   <= CNTW'(WIDTH - 1);
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC:    state <= S_DONE;
        S_MUL_ADD: state <= S_MUL_SHIFT;
        S_MUL_SHIFT: begin
          // cnt counts remaining iterations; it stops at zero instead of wrapping
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= S_MUL_ADD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx      = C_HOLD;
    ty      = C_HOLD;
    tz      = C_HOLD;
    ula_op  = U_PASSY;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      S_EXEC: begin
        case (opcode)
          OP_CLR: begin
            tx = C_CLEAR;
            ty = C_CLEAR;
            tz = C_CLEAR;
          end
          OP_LDX: tx = C_LOAD;
          OP_ADD: begin
            ula_op = U_ADD;
            ty     = C_LOAD;
          end
          OP_SUB: begin
            ula_op = U_SUB;
            ty     = C_LOAD;
          end
          OP_SHR:  ty = C_SHIFTR;
          OP_MOVZ: begin
            ula_op = U_PASSY;
            tz     = C_LOAD;
          end
          default: ;
        endcase
      end
      S_MUL_ADD: begin
        // partial product: accumulate the shifted multiplicand when the multiplier bit is set
        if (y_lsb) begin
          ula_op = U_ADDZ;
          tz     = C_LOAD;
        end
      end
      S_MUL_SHIFT: begin
        tx = C_SHIFTL;
        ty = C_SHIFTR;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = opcode[3];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controle_seq.sv
// tb/tb_cpu_controle_seq.sv - self-checking bench for cpu_controle_seq with a register datapath model
module tb_cpu_controle_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       y_lsb;
  logic [3:0] tx, ty, tz, ula_op;
  logic       done, illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  // datapath model: RegX/RegY/RegZ obeying the issued codes, ULA per the select
  logic [3:0] dx, dy, dz, din;
  logic       preset;
  logic [3:0] px, py, pz;
  logic [3:0] ula_res;

  cpu_controle_seq #(.WIDTH(4), .CW(4)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .y_lsb(y_lsb), .tx(tx), .ty(ty), .tz(tz),
    .ula_op(ula_op), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign y_lsb = dy[0];

  always_comb begin
    case (ula_op)
      4'd1:    ula_res = dx + dy;
      4'd2:    ula_res = dy - dx;
      4'd3:    ula_res = dz + dx;
      default: ula_res = dy;
    endcase
  end

  function automatic logic [3:0] apply(input logic [3:0] code, input logic [3:0] cur, input logic [3:0] ld);
    case (code)
      4'd0:    return 4'd0;
      4'd1:    return ld;
      4'd3:    return cur >> 1;
      4'd4:    return cur << 1;
      default: return cur;
    endcase
  endfunction

  always @(posedge clock) begin
    if (preset) begin
      dx <= px; dy <= py; dz <= pz;
    end else begin
      dx <= apply(tx, dx, din);
      dy <= apply(ty, dy, ula_res);
      dz <= apply(tz, dz, ula_res);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_regs(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
    @(negedge clock);
    px = x; py = y; pz = z; preset = 1'b1;
    @(negedge clock);
    preset = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!instr_ready && g < 30) begin
      @(negedge clock);
      g++;
    end
    if (!instr_ready) check("ready_timeout", 0, 1);
  endtask

  // issues op; lat = edges after the accept edge at which done became visible
  task automatic run_op(input logic [3:0] op, output int lat, output logic ill);
    wait_ready();
    instr = op; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    ill = illegal;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] etx, ety, etz, eula;
    logic       eill;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat;
    logic ill;
    logic seen;
    logic [3:0] ex, ey, ez, op;
    int exp_lat;

    preset = 1'b0; din = 4'd0; px = '0; py = '0; pz = '0;
    vt[0] = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd0, 1'b0};
    vt[1] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vt[2] = '{4'd2, 4'd1, 4'd2, 4'd2, 4'd0, 1'b0};
    vt[3] = '{4'd3, 4'd2, 4'd1, 4'd2, 4'd1, 1'b0};
    vt[4] = '{4'd4, 4'd2, 4'd1, 4'd2, 4'd2, 1'b0};
    vt[5] = '{4'd5, 4'd2, 4'd3, 4'd2, 4'd0, 1'b0};
    vt[6] = '{4'd6, 4'd2, 4'd2, 4'd1, 4'd0, 1'b0};
    vt[7] = '{4'd8, 4'd2, 4'd2, 4'd2, 4'd0, 1'b1};
    vt[8] = '{4'hC, 4'd2, 4'd2, 4'd2, 4'd0, 1'b1};
    vt[9] = '{4'hF, 4'd2, 4'd2, 4'd2, 4'd0, 1'b1};

    // reset held with a pending ADD
    reset_n = 1'b0; instr_valid = 1'b1; instr = 4'd3;
    #23;
    check("rst_tx", tx, 2); check("rst_ty", ty, 2); check("rst_tz", tz, 2);
    check("rst_ula", ula_op, 0); check("rst_ready", instr_ready, 1); check("rst_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    check("first_accept_ty", ty, 1); check("first_accept_ula", ula_op, 1);
    @(negedge clock);
    check("first_done", done, 1);

    // EXEC decode table
    for (int i = 0; i < 10; i++) begin
      wait_ready();
      instr = vt[i].op; instr_valid = 1'b1;
      @(negedge clock);
      instr_valid = 1'b0;
      check($sformatf("tbl%0h_tx", vt[i].op), tx, vt[i].etx);
      check($sformatf("tbl%0h_ty", vt[i].op), ty, vt[i].ety);
      check($sformatf("tbl%0h_tz", vt[i].op), tz, vt[i].etz);
      check($sformatf("tbl%0h_ula", vt[i].op), ula_op, vt[i].eula);
      check($sformatf("tbl%0h_done0", vt[i].op), done, 0);
      @(negedge clock);
      check($sformatf("tbl%0h_done", vt[i].op), done, 1);
      check($sformatf("tbl%0h_ill", vt[i].op), illegal, vt[i].eill);
    end

    // CLR then LDX back-to-back with valid held high
    wait_ready();
    instr = 4'd1; instr_valid = 1'b1;
    @(negedge clock);
    check("b2b_clr", {tx, ty, tz}, 12'h000);
    instr = 4'd2;
    @(negedge clock);
    check("b2b_done", done, 1); check("b2b_ready_in_done", instr_ready, 0);
    @(negedge clock);
    check("b2b_done_gone", done, 0); check("b2b_ready", instr_ready, 1);
    @(negedge clock);
    instr_valid = 1'b0;
    check("b2b_ldx", {tx, ty, tz, ula_op}, 16'h1220);
    @(negedge clock);
    check("b2b_ldx_done", done, 1);

    // directed MUL, multiplier 1011
    load_regs(4'd5, 4'b1011, 4'd0);
    wait_ready();
    instr = 4'd7; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        ex = (4'b1011 >> (k / 2)) & 4'd1;
        check($sformatf("mul_add%0d_tz", k / 2), tz, ex ? 1 : 2);
        check($sformatf("mul_add%0d_ula", k / 2), ula_op, ex ? 3 : 0);
      end else begin
        check($sformatf("mul_sh%0d", k / 2), {tx, ty}, 8'h43);
      end
      check($sformatf("mul_nodone%0d", k), done, 0);
      @(negedge clock);
    end
    check("mul_done", done, 1); check("mul_ill", illegal, 0);
    check("mul_z", dz, (5 * 11) % 16);
    @(negedge clock);
    check("mul_done_pulse", done, 0); check("mul_ready", instr_ready, 1);

    // reset during third MUL cycle
    load_regs(4'd3, 4'd7, 4'd0);
    wait_ready();
    instr = 4'd7; instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_codes", {tx, ty, tz, ula_op}, 16'h2220);
    check("abort_ready", instr_ready, 1); check("abort_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    run_op(4'd0, lat, ill);
    check("nop_after_abort_lat", lat, 1);

    // randomized ops against the arithmetic register model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        load_regs(4'($urandom), 4'($urandom), 4'($urandom));
      wait_ready();
      op = 4'($urandom);
      din = 4'($urandom);
      ex = dx; ey = dy; ez = dz;
      exp_lat = 1;
      case (op)
        4'd1: begin ex = 0; ey = 0; ez = 0; end
        4'd2: ex = din;
        4'd3: ey = dy + dx;
        4'd4: ey = dy - dx;
        4'd5: ey = dy >> 1;
        4'd6: ez = dy;
        4'd7: begin ez = 4'((dz + dx * dy) % 16); ex = 0; ey = 0; exp_lat = 8; end
        default: ;
      endcase
      run_op(op, lat, ill);
      check($sformatf("rnd%0d_op%0h_lat", n, op), lat, exp_lat);
      check($sformatf("rnd%0d_op%0h_ill", n, op), ill, op >= 8);
      check($sformatf("rnd%0d_op%0h_regs", n, op), {dx, dy, dz}, {ex, ey, ez});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
